// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the run-time clock divider controller.
// Optional feature macro used by div_ctrl: DIV_CTRL_CFG_CHECK_EN.
package div_pkg;

    // Controller FSM states. PARKED is the reset state and the idle state.
    typedef enum logic [1:0] {
        PARKED   = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } div_state_e;

    // Smallest ratio the divider can produce (1 high cycle, 1 low cycle).
    localparam int MIN_DIV = 2;

    // Ratio loaded at reset: 100 MHz / 20 = 5 MHz.
    localparam int DEFAULT_RATIO = 20;

endpackage

// File: rtl/div_core.sv
// div_core: divide counter and registered clk_out.
// Holds the active ratio n_act. With run = 1 the counter advances and wraps
// at n_act-1; with run = 0 it sits at the park position (n_act-1, clk_out 0).
// load replaces n_act with n on this edge; the controller only asserts it on
// a wrap edge or while parked, so a new ratio always starts a fresh period.
module div_core #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] n,
    input  logic             run,
    input  logic             load,
    output logic             clk_out,
    output logic             wrap
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] n_act;
    logic [DIV_W-1:0] n_next;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] cnt_next;
    logic             clk_next;

    // Last cycle of the period (also true while parked, since cnt sits at N-1).
    assign wrap = (cnt == (n_act - 1'b1));

    // Next counter / clk_out value: park, wrap into a new high phase, or count.
    always_comb begin
        n_next   = load ? n : n_act;
        cnt_inc  = cnt + 1'b1;
        cnt_next = cnt_inc;
        clk_next = (cnt_inc < (n_act >> 1));
        if (!run) begin
            cnt_next = n_next - 1'b1;
            clk_next = 1'b0;
        end else if (wrap) begin
            cnt_next = '0;
            clk_next = 1'b1;
        end
    end

    // Counter, active ratio and clk_out registers; reset parks with the default ratio.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_act   <= RST_DIV;
            cnt     <= RST_DIV - 1'b1;
            clk_out <= 1'b0;
        end else begin
            n_act   <= n_next;
            cnt     <= cnt_next;
            clk_out <= clk_next;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: run-time controller for the system clock divider.
// Owns the pending ratio and the cfg handshake, and starts/stops the divided
// clock on period boundaries so clk_out never glitches.
//
// cfg handshake: a ratio transfers on an edge where cfg_valid && cfg_ready.
// cfg_ready is low exactly while a ratio is pending; offers made during that
// time are ignored, not queued.
//
// Optional macro DIV_CTRL_CFG_CHECK_EN: ratios below MIN_DIV are consumed by
// the handshake, discarded, and flagged with a one-cycle err pulse. Without
// it, err is tied low and such ratios are clamped to MIN_DIV.
//
// DEFAULT_DIV must be at least MIN_DIV.
module div_ctrl
    import div_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = DEFAULT_RATIO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             busy,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam logic [DIV_W-1:0] MIN_DIV_W = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] RST_DIV   = DIV_W'(DEFAULT_DIV);

    div_state_e       state;
    div_state_e       state_next;
    logic             pending;
    logic [DIV_W-1:0] pend_div;
    logic [DIV_W-1:0] cfg_val;
    logic             accept;
    logic             take;
    logic             wrap;
    logic             run;
    logic             load;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & cfg_ready;
    assign dbg_state = state;

`ifdef DIV_CTRL_CFG_CHECK_EN
    logic err_q;

    assign cfg_val = cfg_div;
    assign take    = accept & (cfg_div >= MIN_DIV_W);
    assign err     = err_q;

    // err pulses in the cycle after a too-small ratio is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept & (cfg_div < MIN_DIV_W);
        end
    end
`else
    assign cfg_val = (cfg_div < MIN_DIV_W) ? MIN_DIV_W : cfg_div;
    assign take    = accept;
    assign err     = 1'b0;
`endif

    // Pending ratio: set on transfer, cleared on the edge that applies it.
    // load needs pending already set, so a ratio accepted on a wrap edge
    // waits for the following boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            pend_div <= RST_DIV;
        end else if (load) begin
            pending  <= 1'b0;
        end else if (take) begin
            pending  <= 1'b1;
            pend_div <= cfg_val;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PARKED;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state. Dropping enable on the wrap cycle parks immediately,
    // since that cycle already ends a complete low phase.
    always_comb begin
        state_next = state;
        case (state)
            PARKED: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (!enable) state_next = wrap ? PARKED : STOPPING;
            end
            STOPPING: begin
                if (enable)    state_next = RUN;
                else if (wrap) state_next = PARKED;
            end
            default: state_next = PARKED;
        endcase
    end

    // FSM outputs: keep the core running except when parking at a wrap,
    // and apply a pending ratio only at a wrap edge or while parked.
    always_comb begin
        run  = 1'b0;
        load = 1'b0;
        busy = 1'b0;
        case (state)
            PARKED: begin
                run  = enable;
                load = pending;
            end
            RUN, STOPPING: begin
                busy = 1'b1;
                run  = enable | ~wrap;
                load = pending & wrap;
            end
            default: begin
                run  = 1'b0;
                load = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

    div_core #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .n       (pend_div),
        .run     (run),
        .load    (load),
        .clk_out (clk_out),
        .wrap    (wrap)
    );

endmodule
